enemy_move_scheduler: RTL and testbench

- Owns the position and alive state of one row of enemies.
- Generates the 2-bit movement phase and the periodic move tick.
- Walks all enemies through a single shared row-move datapath, one enemy per clock.
- Sits between the game timing logic and the renderer/collision logic, which read the packed position bus.

---
 rtl/enemy_move_scheduler_pkg.sv | 34 +++
 rtl/enemy_row_mover.sv | 27 ++
 rtl/enemy_move_scheduler.sv | 157 +++++++++++++++
 tb/tb_enemy_move_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_move_scheduler_pkg.sv
// Shared definitions for the enemy row scheduler.
//   - position geometry (x/y widths, packed position type, dead code)
//   - movement phase encodings and the direction helper
//   - scheduler FSM state encodings
package enemy_move_scheduler_pkg;

  localparam int POS_W = 19;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  // Position code reported for a dead enemy.
  localparam logic [POS_W-1:0] NONE_CODE = {POS_W{1'b1}};

  // Movement phases: right, left, left, right. A full cycle nets zero.
  localparam logic [1:0] PH_R0 = 2'b00;
  localparam logic [1:0] PH_L0 = 2'b01;
  localparam logic [1:0] PH_L1 = 2'b10;
  localparam logic [1:0] PH_R1 = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_UPDATE = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  // x in the upper bits so the packed bus reads {x, y} per enemy.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  function automatic logic isRightward(input logic [1:0] phase);
    return (phase == PH_R0) || (phase == PH_R1);
  endfunction

endpackage

// File: rtl/enemy_row_mover.sv
// Combinational single-enemy move datapath, time-shared across the row.
//   alive   : enemy alive bit
//   pos     : current {x, y}
//   phase   : phase latched for the current step
//   nextPos : moved position, or NONE for a dead enemy
// x wraps modulo 1024 in both directions; y is always re-forced to the row.
module enemy_row_mover
  import enemy_move_scheduler_pkg::*;
#(
  parameter logic [Y_W-1:0]   VERTICAL_POSITION = 9'd108,
  parameter logic [POS_W-1:0] NONE              = NONE_CODE
) (
  input  logic       alive,
  input  pos_t       pos,
  input  logic [1:0] phase,
  output pos_t       nextPos
);

  always_comb begin
    nextPos = NONE;
    if (alive) begin
      nextPos.x = isRightward(phase) ? (pos.x + 10'd1) : (pos.x - 10'd1);
      nextPos.y = VERTICAL_POSITION;
    end
  end

endmodule

// File: rtl/enemy_move_scheduler.sv
// Owns position/alive state for one row of enemies and steps the row on a
// periodic tick, one enemy per clock through a single enemy_row_mover.
//   i_Clk, i_Rst_n      : clock, async active-low reset
//   i_Run               : tick counter enable
//   i_Restart           : sync reinit, beats every other input
//   i_KillValid/KillIdx : kill request
//   o_EnemyPosition     : packed {x,y} per enemy, enemy k at [19k+18:19k]
//   o_EnemyState        : alive bitmap
//   o_PhaseState        : current movement phase
//   o_Busy              : row walk in progress
//   o_StepDone          : one-cycle pulse after each walk
//   o_AllDead           : no enemy alive
module enemy_move_scheduler
  import enemy_move_scheduler_pkg::*;
#(
  parameter int               NUM_ENEMY         = 8,
  parameter logic [31:0]      MOVE_PERIOD       = 32'd2_500_000,
  parameter logic [7:0]       STEPS_PER_PHASE   = 8'd40,
  parameter logic [X_W-1:0]   START_X           = 10'd100,
  parameter logic [X_W-1:0]   SPACING           = 10'd40,
  parameter logic [Y_W-1:0]   VERTICAL_POSITION = 9'd108,
  parameter logic [POS_W-1:0] NONE              = NONE_CODE
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Run,
  input  logic                       i_Restart,
  input  logic                       i_KillValid,
  input  logic [3:0]                 i_KillIdx,
  output logic [POS_W*NUM_ENEMY-1:0] o_EnemyPosition,
  output logic [NUM_ENEMY-1:0]       o_EnemyState,
  output logic [1:0]                 o_PhaseState,
  output logic                       o_Busy,
  output logic                       o_StepDone,
  output logic                       o_AllDead
);

  localparam int IDX_W = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMY - 1);

  pos_t [NUM_ENEMY-1:0] posR;
  logic [NUM_ENEMY-1:0] aliveR;
  logic [31:0]          tickCnt;
  logic [7:0]           stepCnt;
  logic [1:0]           phaseR;
  logic [1:0]           walkPhase;
  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic                 busyR;
  logic                 stepDoneR;
  logic                 tick;
  logic                 killHit;
  logic [IDX_W-1:0]     killSel;
  pos_t                 moverOut;

  function automatic logic [POS_W*NUM_ENEMY-1:0] initRow();
    pos_t [NUM_ENEMY-1:0] row;
    for (int k = 0; k < NUM_ENEMY; k++) begin
      row[k].x = START_X + X_W'(k) * SPACING;
      row[k].y = VERTICAL_POSITION;
    end
    return row;
  endfunction

  assign tick    = i_Run && (tickCnt == MOVE_PERIOD - 32'd1);
  assign killHit = i_KillValid && ({1'b0, i_KillIdx} < 5'(NUM_ENEMY));
  assign killSel = i_KillIdx[IDX_W-1:0];

  // Tick counter runs regardless of FSM state; ticks outside IDLE are lost.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)       tickCnt <= '0;
    else if (i_Restart) tickCnt <= '0;
    else if (i_Run)     tickCnt <= tick ? '0 : tickCnt + 32'd1;
  end

  enemy_row_mover #(
    .VERTICAL_POSITION(VERTICAL_POSITION),
    .NONE             (NONE)
  ) uMover (
    .alive  (aliveR[idx]),
    .pos    (posR[idx]),
    .phase  (walkPhase),
    .nextPos(moverOut)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      posR      <= initRow();
      aliveR    <= '1;
      stepCnt   <= '0;
      phaseR    <= PH_R0;
      walkPhase <= PH_R0;
      state     <= ST_IDLE;
      idx       <= '0;
      busyR     <= 1'b0;
      stepDoneR <= 1'b0;
    end else if (i_Restart) begin
      posR      <= initRow();
      aliveR    <= '1;
      stepCnt   <= '0;
      phaseR    <= PH_R0;
      walkPhase <= PH_R0;
      state     <= ST_IDLE;
      idx       <= '0;
      busyR     <= 1'b0;
      stepDoneR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state     <= ST_UPDATE;
            idx       <= '0;
            walkPhase <= phaseR;
            busyR     <= 1'b1;
          end
        end
        ST_UPDATE: begin
          posR[idx] <= moverOut;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            busyR     <= 1'b0;
            stepDoneR <= 1'b1;
          end
        end
        ST_DONE: begin
          stepDoneR <= 1'b0;
          state     <= ST_IDLE;
          if (stepCnt == STEPS_PER_PHASE - 8'd1) begin
            stepCnt <= '0;
            phaseR  <= phaseR + 2'd1;
          end else begin
            stepCnt <= stepCnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busyR     <= 1'b0;
          stepDoneR <= 1'b0;
        end
      endcase
      // Placed after the walk write so a same-cycle kill on the same slot wins.
      if (killHit) begin
        aliveR[killSel] <= 1'b0;
        posR[killSel]   <= NONE;
      end
    end
  end

  assign o_EnemyPosition = posR;
  assign o_EnemyState    = aliveR;
  assign o_PhaseState    = phaseR;
  assign o_Busy          = busyR;
  assign o_StepDone      = stepDoneR;
  assign o_AllDead       = ~|aliveR;

endmodule

// File: tb/tb_enemy_move_scheduler.sv
module tb_enemy_move_scheduler;
  localparam int N = 4, P = 10, SPE = 3, SP = 20, VY = 108;
  localparam int STA = 100, STW = 0;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, restart = 1'b0, kv = 1'b0;
  logic [3:0] kIdx = 4'd0;
  logic [N*19-1:0] posA, posW;
  logic [N-1:0] stA, stW;
  logic [1:0] phA, phW;
  logic busyA, busyW, sdA, sdW, adA, adW;

  int errors = 0, checks = 0;
  bit chkOn = 0;

  always #5 clk = ~clk;

  enemy_move_scheduler #(.NUM_ENEMY(N), .MOVE_PERIOD(32'd10), .STEPS_PER_PHASE(8'd3),
    .START_X(10'd100), .SPACING(10'd20)) dutA (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Run(run), .i_Restart(restart),
    .i_KillValid(kv), .i_KillIdx(kIdx), .o_EnemyPosition(posA), .o_EnemyState(stA),
    .o_PhaseState(phA), .o_Busy(busyA), .o_StepDone(sdA), .o_AllDead(adA));

  enemy_move_scheduler #(.NUM_ENEMY(N), .MOVE_PERIOD(32'd10), .STEPS_PER_PHASE(8'd3),
    .START_X(10'd0), .SPACING(10'd20)) dutW (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Run(run), .i_Restart(restart),
    .i_KillValid(kv), .i_KillIdx(kIdx), .o_EnemyPosition(posW), .o_EnemyState(stW),
    .o_PhaseState(phW), .o_Busy(busyW), .o_StepDone(sdW), .o_AllDead(adW));

  // Model: an enemy's x is its start plus the net displacement of the
  // steps it has taken; the phase of step s is (s / SPE) % 4.
  int mCnt, mSteps, mWalk;  // mWalk: -1 idle, 0..N-1 enemy being moved, N step finishing
  int mMoved[N];
  logic [N-1:0] mAlive;
  bit mTick;

  task automatic mInit();
    mCnt = 0; mSteps = 0; mWalk = -1; mAlive = '1;
    for (int k = 0; k < N; k++) mMoved[k] = 0;
  endtask

  function automatic int dirOf(input int ph);
    return (ph == 0 || ph == 3) ? 1 : -1;
  endfunction

  function automatic logic [18:0] expPos(input int start, input int k, input logic alive, input int moved);
    int x;
    logic [9:0] xs;
    if (!alive) return '1;
    x = start + k * SP;
    for (int s = 0; s < moved; s++) x += dirOf((s / SPE) % 4);
    x = ((x % 1024) + 1024) % 1024;
    xs = x[9:0];
    return {xs, 9'(VY)};
  endfunction

  initial begin
    mInit();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || restart) mInit();
      else begin
        mTick = run && (mCnt == P - 1);
        if (run) mCnt = (mCnt == P - 1) ? 0 : mCnt + 1;
        if (mWalk == -1) begin
          if (mTick) mWalk = 0;
        end else if (mWalk == N) begin
          mSteps++; mWalk = -1;
        end else begin
          if (mAlive[mWalk]) mMoved[mWalk]++;
          mWalk++;
        end
        if (kv && kIdx < 4'(N)) mAlive[int'(kIdx)] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [9:0] xOf(input logic [N*19-1:0] bus, input int k);
    return bus[k*19+9 +: 10];
  endfunction

  // Cycle-by-cycle compare of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (chkOn) begin
      for (int k = 0; k < N; k++) begin
        chk("posA", 32'(posA[k*19 +: 19]), 32'(expPos(STA, k, mAlive[k], mMoved[k])));
        chk("posW", 32'(posW[k*19 +: 19]), 32'(expPos(STW, k, mAlive[k], mMoved[k])));
      end
      chk("stateA", 32'(stA), 32'(mAlive));
      chk("stateW", 32'(stW), 32'(mAlive));
      chk("phaseA", 32'(phA), 32'((mSteps / SPE) % 4));
      chk("phaseW", 32'(phW), 32'((mSteps / SPE) % 4));
      chk("busyA", 32'(busyA), 32'(mWalk >= 0 && mWalk < N));
      chk("busyW", 32'(busyW), 32'(mWalk >= 0 && mWalk < N));
      chk("stepDoneA", 32'(sdA), 32'(mWalk == N));
      chk("stepDoneW", 32'(sdW), 32'(mWalk == N));
      chk("allDeadA", 32'(adA), 32'(mAlive == '0));
      chk("allDeadW", 32'(adW), 32'(mAlive == '0));
    end
  end

  int busyCycles = 0;
  initial forever begin
    @(negedge clk);
    if (busyA) busyCycles++;
  end

  task automatic waitStep(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sdA) break;
      n++;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL waitStep: no step pulse within %0d cycles", budget);
        break;
      end
    end
  endtask

  task automatic waitBusy(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (busyA) break;
      n++;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL waitBusy: no busy within %0d cycles", budget);
        break;
      end
    end
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int sdSeen;
  initial begin
    repeat (2) @(posedge clk);
    #1 chkOn = 1;
    @(negedge clk);
    chk("rst x0", 32'(xOf(posA, 0)), 100);
    chk("rst x3", 32'(xOf(posA, 3)), 160);
    chk("rst y0", 32'(posA[8:0]), 108);
    chk("rst state", 32'(stA), 32'hF);
    chk("rst busy", 32'(busyA), 0);

    // First step
    edge1(); rst_n = 1'b1; run = 1'b1;
    busyCycles = 0;
    waitStep(40);
    chk("step1 busy cycles", 32'(busyCycles), 4);
    chk("step1 x0", 32'(xOf(posA, 0)), 101);
    chk("step1 x1", 32'(xOf(posA, 1)), 121);
    chk("step1 x2", 32'(xOf(posA, 2)), 141);
    chk("step1 x3", 32'(xOf(posA, 3)), 161);

    // Phase cycling
    repeat (2) waitStep(40);
    @(negedge clk);
    chk("phase after 3", 32'(phA), 1);
    repeat (4) waitStep(40);
    @(negedge clk);
    chk("phase after 7", 32'(phA), 2);
    chk("wrap x0", 32'(xOf(posW, 0)), 1023);
    chk("step7 x0", 32'(xOf(posA, 0)), 99);
    repeat (5) waitStep(40);
    @(negedge clk);
    chk("phase after 12", 32'(phA), 0);
    chk("cycle x0", 32'(xOf(posA, 0)), 100);
    chk("cycle x2", 32'(xOf(posA, 2)), 140);
    chk("cycle x3", 32'(xOf(posA, 3)), 160);

    // Pause holds the counter
    edge1(); run = 1'b0;
    sdSeen = 0;
    repeat (30) begin @(negedge clk); if (sdA || busyA) sdSeen++; end
    chk("pause no activity", 32'(sdSeen), 0);
    edge1(); run = 1'b1;

    // Kill enemy 2 on the cycle it is being written
    waitBusy(40);
    @(posedge clk);
    edge1(); kv = 1'b1; kIdx = 4'd2;
    edge1(); kv = 1'b0;
    @(negedge clk);
    chk("kill state", 32'(stA), 32'b1011);
    chk("kill pos2", 32'(posA[2*19 +: 19]), 32'h7FFFF);
    repeat (2) waitStep(40);
    chk("dead stays", 32'(posA[2*19 +: 19]), 32'h7FFFF);
    chk("step14 x0", 32'(xOf(posA, 0)), 102);

    // Out-of-range kill
    edge1(); kv = 1'b1; kIdx = 4'd7;
    edge1(); kv = 1'b0;
    @(negedge clk);
    chk("kill7 state", 32'(stA), 32'b1011);

    // Async reset mid-walk
    waitBusy(40);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("areset busy", 32'(busyA), 0);
    chk("areset x0", 32'(xOf(posA, 0)), 100);
    chk("areset state", 32'(stA), 32'hF);
    chk("areset phase", 32'(phA), 0);
    edge1(); rst_n = 1'b1;

    // Sync restart mid-walk
    waitBusy(40);
    edge1(); restart = 1'b1;
    edge1(); restart = 1'b0;
    @(negedge clk);
    chk("restart busy", 32'(busyA), 0);
    chk("restart x1", 32'(xOf(posA, 1)), 120);

    // Kill all, then restart
    for (int i = 0; i < N; i++) begin
      edge1(); kv = 1'b1; kIdx = 4'(i);
    end
    edge1(); kv = 1'b0;
    @(negedge clk);
    chk("all dead", 32'(adA), 1);
    edge1(); restart = 1'b1;
    edge1(); restart = 1'b0;
    @(negedge clk);
    chk("alive after restart", 32'(adA), 0);
    chk("state after restart", 32'(stA), 32'hF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
